// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb native master bridge: registers one Wishbone
// request, runs a single outstanding IOb transaction and returns ack or error.
module iob_wishbone2iob #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic [ADDR_W-1:0]   wb_addr_i,
   input  logic [DATA_W/8-1:0] wb_select_i,
   input  logic                wb_we_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic [DATA_W-1:0]   wb_data_i,
   output logic [DATA_W-1:0]   wb_data_o,
   output logic                wb_ack_o,
   output logic                wb_error_o,
   output logic                valid_o,
   output logic [ADDR_W-1:0]   address_o,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [DATA_W/8-1:0] wstrb_o,
   input  logic [DATA_W-1:0]   rdata_i,
   input  logic                ready_i
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   logic [1:0]           state_r;
   logic [TIMEOUT_W-1:0] cnt_r;
   logic [TIMEOUT_W-1:0] cnt_inc_s;
   logic                 timeout_hit_s;
   logic                 is_read_s;

   // Wait-counter lookahead and transaction direction decode.
   always_comb begin
      cnt_inc_s     = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      timeout_hit_s = (TIMEOUT != 32'sd0) && (cnt_inc_s == TIMEOUT_W'(TIMEOUT));
      is_read_s     = (wstrb_o == {(DATA_W/8){1'b0}});
   end

   // Bridge FSM with all outputs registered.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_r    <= IDLE;
         cnt_r      <= {TIMEOUT_W{1'b0}};
         wb_data_o  <= {DATA_W{1'b0}};
         wb_ack_o   <= 1'b0;
         wb_error_o <= 1'b0;
         valid_o    <= 1'b0;
         address_o  <= {ADDR_W{1'b0}};
         wdata_o    <= {DATA_W{1'b0}};
         wstrb_o    <= {(DATA_W/8){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               wb_ack_o   <= 1'b0;
               wb_error_o <= 1'b0;
               if (wb_cyc_i && wb_stb_i) begin
                  address_o <= wb_addr_i;
                  wdata_o   <= wb_data_i;
                  wstrb_o   <= wb_we_i ? wb_select_i : {(DATA_W/8){1'b0}};
                  valid_o   <= 1'b1;
                  cnt_r     <= {TIMEOUT_W{1'b0}};
                  state_r   <= REQ;
               end else begin
                  state_r <= IDLE;
               end
            end
            REQ: begin
               // The IOb side cannot abort, so a dropped cycle only suppresses the reply.
               if (ready_i) begin
                  valid_o <= 1'b0;
                  if (wb_cyc_i) begin
                     wb_data_o <= is_read_s ? rdata_i : {DATA_W{1'b0}};
                     wb_ack_o  <= 1'b1;
                     state_r   <= ACK;
                  end else begin
                     state_r <= IDLE;
                  end
               end else if (timeout_hit_s) begin
                  valid_o    <= 1'b0;
                  wb_data_o  <= {DATA_W{1'b0}};
                  wb_error_o <= wb_cyc_i;
                  state_r    <= wb_cyc_i ? ERR : IDLE;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ACK: begin
               wb_ack_o <= 1'b0;
               state_r  <= IDLE;
            end
            ERR: begin
               wb_error_o <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               valid_o    <= 1'b0;
               wb_ack_o   <= 1'b0;
               wb_error_o <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

endmodule
